ram_march_ctrl: RTL and testbench



---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_march_cmp.sv | 71 +++++++
 rtl/ram_march_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_march_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants, FSM state encoding and the march test pattern for the
// 8x8 RAM self-test sequencer.
package ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] SEED     = 8'hA5;
  localparam logic [DATA_W-1:0] STEP     = 8'h1F;
  localparam logic [ADDR_W-1:0] ERR_ADDR = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Pattern for address a; the second pass uses the bitwise inverse.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic inv);
    logic [DATA_W-1:0] p;
    p = SEED + (DATA_W'(a) * STEP);
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_march_cmp.sv
// Read-back compare stage: holds the expected value/address for the read
// issued last cycle, flags mismatches against the registered RAM output,
// keeps a saturating error count and latches the first failing location.
module ram_march_cmp
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              pass_idx_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [3:0]        err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              fail_pass_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pidx_q;
  logic [3:0]        err_q;
  logic [ADDR_W-1:0] faddr_q;
  logic              fpass_q;
  logic              mismatch;

  assign mismatch = vld_q && (rd_data_i != exp_q);

  // Pipeline stage aligning the expected value with the 1-cycle RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      exp_q  <= '0;
      addr_q <= '0;
      pidx_q <= 1'b0;
    end else begin
      vld_q <= load_i;
      if (load_i) begin
        exp_q  <= exp_i;
        addr_q <= addr_i;
        pidx_q <= pass_idx_i;
      end
    end
  end

  // Error count saturates at 15, so zero reliably marks "no mismatch yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      faddr_q <= '0;
      fpass_q <= 1'b0;
    end else if (clr_i) begin
      err_q   <= '0;
      faddr_q <= '0;
      fpass_q <= 1'b0;
    end else if (mismatch) begin
      if (err_q == 4'd0) begin
        faddr_q <= addr_q;
        fpass_q <= pidx_q;
      end
      if (err_q != 4'hF) err_q <= err_q + 4'd1;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = faddr_q;
  assign fail_pass_o = fpass_q;

endmodule

// File: rtl/ram_march_ctrl.sv
// Two-pass march self-test for the 8x8 synchronous RAM: fill with the
// pattern, read back and compare, then repeat with the inverted pattern.
// Optional macro RAM_MARCH_ERR_INJECT_EN flips bit 0 of the pass-0 write
// to ERR_ADDR so the failure-reporting path can be exercised.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for start; results of last test held
// WRITE    | one RAM write per cycle, address 0..DEPTH-1
// READ     | one RAM read per cycle, compare of previous read
// DRAIN    | final compare of the last read of the pass
// DONE     | one-cycle done pulse, pass flag becomes valid
module ram_march_ctrl
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_pass,
  output logic              ram_W,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pidx_q, pidx_d;
  logic              pvld_q, pvld_d;
  logic              clr;
  logic              last;
  logic [DATA_W-1:0] wr_pat;

  assign last = (cnt_q == ADDR_W'(DEPTH - 1));

  // Next-state logic; the counter wraps to 0 on its own after DEPTH-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pidx_d  = pidx_q;
    pvld_d  = pvld_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          pidx_d  = 1'b0;
          pvld_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = ST_READ;
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pidx_q) begin
          pidx_d  = 1'b1;
          state_d = ST_WRITE;
        end else begin
          pvld_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, address counter, pass index and result-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pidx_q  <= 1'b0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pidx_q  <= pidx_d;
      pvld_q  <= pvld_d;
    end
  end

  assign wr_pat = pattern(cnt_q, pidx_q);

`ifdef RAM_MARCH_ERR_INJECT_EN
  logic inj;
  assign inj         = !pidx_q && (cnt_q == ERR_ADDR);
  assign ram_data_in = (state_q == ST_WRITE) ? (wr_pat ^ {{(DATA_W-1){1'b0}}, inj}) : '0;
`else
  assign ram_data_in = (state_q == ST_WRITE) ? wr_pat : '0;
`endif

  assign ram_W    = (state_q == ST_WRITE);
  assign ram_addr = cnt_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  // err_count already includes the DRAIN compare when DONE is entered.
  assign pass     = pvld_q && (err_count == 4'd0);

  ram_march_cmp u_cmp (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .load_i      (state_q == ST_READ),
    .exp_i       (wr_pat),
    .addr_i      (cnt_q),
    .pass_idx_i  (pidx_q),
    .rd_data_i   (ram_data_out),
    .err_count_o (err_count),
    .fail_addr_o (fail_addr),
    .fail_pass_o (fail_pass)
  );

endmodule

// File: tb/tb_ram_march_ctrl.sv
// Self-checking bench for ram_march_ctrl with a behavioural 8x8 RAM whose
// read path can be corrupted (stuck bit, all-zero, random xor fault).
module tb_ram_march_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, fail_pass, ram_W;
  logic [3:0] err_count;
  logic [2:0] fail_addr, ram_addr;
  logic [7:0] ram_data_in, ram_data_out;

  int checks   = 0;
  int failures = 0;

  int         mode   = 0;
  logic [2:0] f_addr = 3'd0;
  logic [7:0] f_mask = 8'h00;
  logic [7:0] mem [8];
  logic [7:0] rdq = 8'h00;
  logic [10:0] wq [$];

  typedef struct {
    int         mode;
    logic [3:0] err;
    logic [2:0] fa;
    logic       fp;
    logic       ok;
  } vec_t;
  vec_t tbl [3];

  always #5 clk = ~clk;
  assign ram_data_out = rdq;

  ram_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
    .fail_pass(fail_pass), .ram_W(ram_W), .ram_data_in(ram_data_in),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out)
  );

  function automatic logic [7:0] pat(int a, bit inv);
    logic [7:0] p;
    p = 8'hA5 + 8'(a * 31);
    return inv ? ~p : p;
  endfunction

  function automatic logic [7:0] wr_val(int a, bit p);
    logic [7:0] w;
    w = pat(a, p);
`ifdef RAM_MARCH_ERR_INJECT_EN
    if (!p && a == 5) w[0] = ~w[0];
`endif
    return w;
  endfunction

  function automatic logic [7:0] fault(logic [7:0] v, logic [2:0] a);
    case (mode)
      1:       return (a == 3'd3) ? (v & 8'h7F) : v;
      2:       return 8'h00;
      3:       return (a == f_addr) ? (v ^ f_mask) : v;
      default: return v;
    endcase
  endfunction

  // Behavioural RAM: write on ram_W, registered (faulty) read every cycle.
  always @(posedge clk) begin
    if (ram_W) begin
      mem[ram_addr] <= ram_data_in;
      wq.push_back({ram_addr, ram_data_in});
    end
    rdq <= fault(mem[ram_addr], ram_addr);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: both passes, each location written then read through fault.
  task automatic model(output logic [3:0] e, output logic [2:0] fa, output logic fp);
    e = 0; fa = 0; fp = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 8; a++)
        if (fault(wr_val(a, p[0]), 3'(a)) != pat(a, p[0])) begin
          if (e == 0) begin fa = 3'(a); fp = p[0]; end
          if (e < 15) e++;
        end
  endtask

  // One test: optional extra start pulses and optional mid-test reset.
  task automatic do_run(input int pulse_a, input int pulse_b, input int rst_at,
                        output int lat, output bit got_done);
    int cyc;
    wq.delete();
    got_done = 0; lat = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); cyc = 1; #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (cyc < 60 && !got_done) begin
      if (cyc == pulse_a || cyc == pulse_b) start = 1'b1;
      if (cyc == rst_at) begin
        chk("ramw_before_rst", ram_W, (cyc <= 8) ? 1 : 0);
        #3 rst = 1'b1;
        #1 chk("busy_async_rst", busy, 0);
        chk("ramw_async_rst", ram_W, 0);
      end
      @(posedge clk); cyc++; #1 start = 1'b0;
      if (done) begin got_done = 1; lat = cyc; end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int lat;
    bit got;
    logic [3:0] e;
    logic [2:0] fa;
    logic fp;

`ifdef RAM_MARCH_ERR_INJECT_EN
    tbl[0] = '{mode: 0, err: 4'd1,  fa: 3'd5, fp: 1'b0, ok: 1'b0};
    tbl[1] = '{mode: 1, err: 4'd2,  fa: 3'd5, fp: 1'b0, ok: 1'b0};
    tbl[2] = '{mode: 2, err: 4'd15, fa: 3'd0, fp: 1'b0, ok: 1'b0};
`else
    tbl[0] = '{mode: 0, err: 4'd0,  fa: 3'd0, fp: 1'b0, ok: 1'b1};
    tbl[1] = '{mode: 1, err: 4'd1,  fa: 3'd3, fp: 1'b1, ok: 1'b0};
    tbl[2] = '{mode: 2, err: 4'd15, fa: 3'd0, fp: 1'b0, ok: 1'b0};
`endif
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);       chk("rst_err", err_count, 0);
    chk("rst_faddr", fail_addr, 0); chk("rst_fpass", fail_pass, 0);
    chk("rst_ramw", ram_W, 0);      chk("rst_wdata", ram_data_in, 0);
    chk("rst_addr", ram_addr, 0);

    // start together with rst: reset wins
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 chk("rst_start_busy", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1 chk("rst_start_busy2", busy, 0);

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      do_run(0, 0, 0, lat, got);
      chk($sformatf("done_seen[%0d]", i), got, 1);
      chk($sformatf("latency[%0d]", i), lat, 35);
      chk($sformatf("err_count[%0d]", i), err_count, tbl[i].err);
      chk($sformatf("fail_addr[%0d]", i), fail_addr, tbl[i].fa);
      chk($sformatf("fail_pass[%0d]", i), fail_pass, tbl[i].fp);
      chk($sformatf("pass[%0d]", i), pass, tbl[i].ok);
      if (i == 0) begin
        chk("write_count", wq.size(), 16);
        for (int k = 0; k < 16 && k < wq.size(); k++)
          chk($sformatf("write[%0d]", k), wq[k], {3'(k % 8), wr_val(k % 8, k >= 8)});
        for (int a = 0; a < 8; a++)
          chk($sformatf("mem_final[%0d]", a), mem[a], pat(a, 1));
      end
      // start during the done cycle is ignored
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk($sformatf("done_pulse[%0d]", i), done, 0);
      chk($sformatf("start_at_done_ignored[%0d]", i), busy, 0);
      chk($sformatf("pass_held[%0d]", i), pass, tbl[i].ok);
    end

    // extra starts while busy do not restart the sequence
    mode = 0;
    do_run(5, 20, 0, lat, got);
    chk("pulses_done", got, 1);
    chk("pulses_latency", lat, 35);
    chk("pulses_err", err_count, 0);

    // reset mid-read and mid-write: abort, no done
    do_run(0, 0, 12, lat, got);
    chk("rst12_no_done", got, 0);
    do_run(0, 0, 4, lat, got);
    chk("rst4_no_done", got, 0);
    chk("rst4_err", err_count, 0);
    do_run(0, 0, 0, lat, got);
    chk("fresh_done", got, 1);
    chk("fresh_latency", lat, 35);
    chk("fresh_pass", pass, tbl[0].ok);

    // randomized single-location read faults against the reference model
    mode = 3;
    for (int r = 0; r < 8; r++) begin
      f_addr = 3'($urandom_range(0, 7));
      f_mask = (r % 3 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      model(e, fa, fp);
      do_run(0, 0, 0, lat, got);
      chk($sformatf("rnd_done[%0d]", r), got, 1);
      chk($sformatf("rnd_err[%0d]", r), err_count, e);
      chk($sformatf("rnd_faddr[%0d]", r), fail_addr, fa);
      chk($sformatf("rnd_fpass[%0d]", r), fail_pass, fp);
      chk($sformatf("rnd_pass[%0d]", r), pass, (e == 0) ? 1 : 0);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
